// File: rtl/temp_ascii_formatter.sv
// Converts one ADT7420 reading (or an I2C failure) into an ASCII record such as "+025.0625\r\n"
// and streams it byte by byte to uart_tx over its start/done handshake.
module temp_ascii_formatter #(
  parameter int TX_TIMEOUT = 100000,
  parameter bit EMIT_CRLF  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_fail,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  input  logic        tx_done_tick,
  output logic        busy,
  output logic        tx_abort
);

  localparam int               CNT_W     = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TX_TIMEOUT - 1);
  localparam logic [3:0]       ITER_LAST = 4'd13;
  localparam logic [3:0]       NORM_LAST = EMIT_CRLF ? 4'd10 : 4'd8;
  localparam logic [3:0]       FAIL_LAST = EMIT_CRLF ? 4'd4 : 4'd2;

  typedef enum logic [1:0] {IDLE, CONV, SEND, WAIT} state_t;

  state_t state, state_next;

  logic [3:0]       iter;
  logic [3:0]       idx;
  logic [3:0]       last_idx;
  logic [3:0]       next_idx;
  logic [CNT_W-1:0] cnt;

  logic        rec_neg;
  logic        rec_fail;
  logic [13:0] int_bin;
  logic [13:0] frac_bin;
  logic [11:0] int_bcd;
  logic [15:0] frac_bcd;

  logic signed [12:0] temp_in;
  logic signed [12:0] temp_neg;
  logic [12:0]        mag_in;
  logic [13:0]        int_in;
  logic [13:0]        frac_in;
  logic               unused_low_bits;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  function automatic logic [11:0] dabble_int(input logic [11:0] bcd, input logic bit_in);
    logic [11:0] adj;
    for (int i = 0; i < 3; i++)
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    return {adj[10:0], bit_in};
  endfunction

  function automatic logic [15:0] dabble_frac(input logic [15:0] bcd, input logic bit_in);
    logic [15:0] adj;
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    return {adj[14:0], bit_in};
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] record_byte(input logic [3:0]  k,
                                             input logic        is_fail,
                                             input logic        is_neg,
                                             input logic [11:0] ib,
                                             input logic [15:0] fb);
    logic [7:0] b;
    b = 8'h00;
    if (is_fail) begin
      case (k)
        4'd0:       b = 8'h45;
        4'd1, 4'd2: b = 8'h52;
        4'd3:       b = 8'h0D;
        4'd4:       b = 8'h0A;
        default:    b = 8'h00;
      endcase
    end else begin
      case (k)
        4'd0:    b = is_neg ? 8'h2D : 8'h2B;
        4'd1:    b = ascii_digit(ib[11:8]);
        4'd2:    b = ascii_digit(ib[7:4]);
        4'd3:    b = ascii_digit(ib[3:0]);
        4'd4:    b = 8'h2E;
        4'd5:    b = ascii_digit(fb[15:12]);
        4'd6:    b = ascii_digit(fb[11:8]);
        4'd7:    b = ascii_digit(fb[7:4]);
        4'd8:    b = ascii_digit(fb[3:0]);
        4'd9:    b = 8'h0D;
        4'd10:   b = 8'h0A;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  // Magnitude of the 13-bit reading; -4096 maps to 4096, which still fits 13 unsigned bits.
  assign temp_in         = $signed(in_data[15:3]);
  assign temp_neg        = -temp_in;
  assign mag_in          = temp_in[12] ? $unsigned(temp_neg) : $unsigned(temp_in);
  assign int_in          = {5'd0, mag_in[12:4]};
  assign frac_in         = {10'd0, mag_in[3:0]} * 14'd625;
  assign unused_low_bits = ^in_data[2:0];

  assign last_idx = rec_fail ? FAIL_LAST : NORM_LAST;
  assign next_idx = (state == CONV) ? 4'd0 : idx + 4'd1;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    tx_start   = 1'b0;
    tx_abort   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = CONV;
      end
      CONV: begin
        if (iter == ITER_LAST) state_next = SEND;
      end
      SEND: begin
        tx_start   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (tx_done_tick) begin
          state_next = (idx == last_idx) ? IDLE : SEND;
        end else if (cnt == CNT_LAST) begin
          tx_abort   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control: state, counters and the transmit byte register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      iter    <= 4'd0;
      idx     <= 4'd0;
      cnt     <= '0;
      tx_byte <= 8'h00;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          iter <= 4'd0;
          idx  <= 4'd0;
        end
        CONV:    iter <= iter + 4'd1;
        SEND:    cnt  <= '0;
        WAIT:    cnt  <= cnt + 1'b1;
        default: ;
      endcase
      // Byte 0 depends only on sign/fail, so it can be loaded on the last conversion step.
      if (state_next == SEND) begin
        idx     <= next_idx;
        tx_byte <= record_byte(next_idx, rec_fail, rec_neg, int_bcd, frac_bcd);
      end
    end
  end

  // Datapath: latch reading, then 14 parallel double-dabble iterations
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      rec_neg  <= temp_in[12];
      rec_fail <= in_fail;
      int_bin  <= int_in;
      frac_bin <= frac_in;
      int_bcd  <= 12'd0;
      frac_bcd <= 16'd0;
    end else if (state == CONV) begin
      int_bcd  <= dabble_int(int_bcd, int_bin[13]);
      frac_bcd <= dabble_frac(frac_bcd, frac_bin[13]);
      int_bin  <= {int_bin[12:0], 1'b0};
      frac_bin <= {frac_bin[12:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_temp_ascii_formatter.sv
// Randomized bench for temp_ascii_formatter: UART model with random done latency and a
// string-level record model that checks every byte, handshake timing, abort and reset.
module tb_temp_ascii_formatter;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_fail = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        tx_done_tick = 1'b0;
  logic        in_ready, tx_start, busy, tx_abort;
  logic [7:0]  tx_byte;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  temp_ascii_formatter #(.TX_TIMEOUT(TO), .EMIT_CRLF(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_fail(in_fail), .tx_start(tx_start), .tx_byte(tx_byte),
    .tx_done_tick(tx_done_tick), .busy(busy), .tx_abort(tx_abort)
  );

  initial forever begin
    #5 clk = 1'b1;
    cyc++;
    #5 clk = 1'b0;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected record text straight from the number: sign, 3.4 decimal digits, CR LF.
  function automatic string model_rec(input logic [15:0] d, input logic f);
    int t, mag, ip, fp;
    string s;
    t = int'($signed(d[15:3]));
    if (f) s = "ERR";
    else begin
      mag = (t < 0) ? -t : t;
      ip  = mag / 16;
      fp  = (mag % 16) * 625;
      s   = $sformatf("%s%03d.%04d", (t < 0) ? "-" : "+", ip, fp);
    end
    s = {s, "\r\n"};
    return s;
  endfunction

  function automatic string hexs(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
    return r;
  endfunction

  task automatic pin(input logic [15:0] d, input logic f, input string want);
    string got;
    got = model_rec(d, f);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL pin_%04h: got %s expected %s", d, hexs(got), hexs(want));
    end
  endtask

  // UART transmitter model
  int done_at = -1;
  int fix_delay = 0;
  bit hang = 1'b0;
  bit stray_en = 1'b0;

  initial forever begin
    @(negedge clk);
    if (reset) done_at = -1;
    else if (tx_start)
      done_at = hang ? -1 : cyc + ((fix_delay > 0) ? fix_delay : int'($urandom_range(1, TO)));
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (done_at == cyc) begin
      tx_done_tick = 1'b1;
      done_at      = -1;
    end else begin
      tx_done_tick = stray_en && (done_at < 0) && ($urandom_range(0, 7) == 0);
    end
  end

  // Compare process
  bit         armed = 1'b0, idle = 1'b1, outstanding = 1'b0, chk_rst = 1'b0;
  bit         exp_abort, now_idle;
  int         start_at = -1, sent_at = 0, pos = 0;
  int         accepted = 0, completed = 0, aborts = 0;
  string      exp_rec = "";
  logic [7:0] held = 8'h00;

  initial forever begin
    @(negedge clk);
    if (armed) begin
      if (chk_rst) begin
        chk("rst_tx_byte", 32'(tx_byte), 32'h00);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_abort", 32'(tx_abort), 32'd0);
        chk_rst = 1'b0;
      end
      chk("in_ready", 32'(in_ready), 32'(idle));
      chk("busy", 32'(busy), 32'(!idle));
      chk("tx_start", 32'(tx_start), 32'(cyc == start_at));
      if (tx_start && cyc == start_at) begin
        chk($sformatf("tx_byte[%0d]", pos), 32'(tx_byte), 32'(exp_rec[pos]));
        held        = exp_rec[pos];
        pos++;
        outstanding = 1'b1;
        sent_at     = cyc;
        start_at    = -1;
      end else if (outstanding) begin
        chk("tx_byte_hold", 32'(tx_byte), 32'(held));
      end
      exp_abort = outstanding && (cyc == sent_at + TO) && !tx_done_tick;
      chk("tx_abort", 32'(tx_abort), 32'(exp_abort));
      if (tx_abort) aborts++;
      now_idle = idle;
      if (reset) begin
        idle        = 1'b1;
        outstanding = 1'b0;
        start_at    = -1;
        chk_rst     = 1'b1;
      end else begin
        if (outstanding && cyc > sent_at && tx_done_tick) begin
          outstanding = 1'b0;
          if (pos == exp_rec.len()) begin
            idle = 1'b1;
            completed++;
          end else begin
            start_at = cyc + 1;
          end
        end else if (exp_abort) begin
          outstanding = 1'b0;
          idle        = 1'b1;
        end
        if (now_idle && in_valid) begin
          idle     = 1'b0;
          exp_rec  = model_rec(in_data, in_fail);
          pos      = 0;
          start_at = cyc + 15;
          accepted++;
        end
      end
    end else if (reset) begin
      armed   = 1'b1;
      chk_rst = 1'b1;
      idle    = 1'b1;
    end
  end

  task automatic send(input logic [15:0] d, input logic f);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_fail  = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 32'd1);
  endtask

  logic [15:0] dirs [6] = '{16'h0C80, 16'hF378, 16'h7FF8, 16'h8000, 16'h0007, 16'h1234};
  bit          dfail[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int a0, c0;
    bit found;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    pin(16'h0C80, 1'b0, "+025.0000\r\n");
    pin(16'hF378, 1'b0, "-025.0625\r\n");
    pin(16'h7FF8, 1'b0, "+255.9375\r\n");
    pin(16'h8000, 1'b0, "-256.0000\r\n");
    pin(16'h0007, 1'b0, "+000.0000\r\n");
    pin(16'h1234, 1'b1, "ERR\r\n");

    stray_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(dirs[i], dfail[i]);
      wait_idle();
    end

    for (int i = 0; i < 16; i++) begin
      fix_delay = (i % 5 == 2) ? TO : 0;
      send(16'($urandom), ($urandom_range(0, 7) == 0));
      wait_idle();
    end
    fix_delay = 0;

    // Byte never completes: exactly one abort, then idle
    stray_en = 1'b0;
    hang     = 1'b1;
    a0       = aborts;
    send(16'h0C80, 1'b0);
    wait_idle();
    hang = 1'b0;
    chk("abort_count", 32'(aborts - a0), 32'd1);

    // in_valid held with changing data: only values present at acceptance are sent
    stray_en = 1'b1;
    c0       = accepted;
    @(posedge clk);
    #1 in_valid = 1'b1;
    for (int i = 0; i < 3000 && accepted < c0 + 2; i++) begin
      in_data = 16'($urandom);
      in_fail = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("held_accepts", 32'(accepted - c0), 32'd2);
    wait_idle();

    // Reset while waiting on byte 4, then a clean record
    stray_en  = 1'b0;
    fix_delay = 40;
    send(16'h0C80, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (outstanding && pos == 5 && cyc > sent_at) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_byte4_wait", 32'(found), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    c0 = completed;
    send(16'h0C80, 1'b0);
    wait_idle();
    chk("record_after_reset", 32'(completed - c0), 32'd1);
    fix_delay = 0;

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/temp_ascii_formatter.md
Name: temp_ascii_formatter

Overview:
Downstream neighbour of the I2C-to-UART arbiter. It takes one completed 2-byte ADT7420 temperature reading, or a failure flag, and converts it to a fixed-format ASCII record. It then streams the record byte by byte to the UART transmitter using its start/done handshake, so the PC console shows readable text, e.g. "+025.0625\r\n". The block sits between the arbiter's data output and the registered tx_start/tx_byte inputs of uart_tx.

Parameters:
TX_TIMEOUT, 100000, clock cycles to wait for tx_done_tick per byte before aborting the record
EMIT_CRLF, 1, 1: append CR (0x0D) and LF (0x0A) to every record; 0: no terminator

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
in_valid  input  1  reading available from arbiter
in_ready  output  1  block can accept a reading (high only in IDLE)
in_data  input  16  raw ADT7420 temperature register, MSB first; [15:3] = 13-bit two's-complement temperature, LSB = 0.0625 C; [2:0] ignored
in_fail  input  1  I2C operation failed; the record becomes "ERR"
tx_start  output  1  one-cycle pulse requesting transmission of tx_byte
tx_byte  output  8  byte to transmit; held stable from the tx_start pulse until tx_done_tick
tx_done_tick  input  1  uart_tx finished the current byte
busy  output  1  high in every state except IDLE
tx_abort  output  1  one-cycle pulse when a byte times out

Behaviour:
- Reset: state=IDLE, in_ready=1, busy=0, tx_start=0, tx_byte=0x00, tx_abort=0, byte index=0, timeout counter=0. Reset mid-record drops the record immediately; no further tx_start is issued.
- States: IDLE, CONV, SEND, WAIT.
- IDLE: in_ready=1. When in_valid=1, latch in_data and in_fail in the same cycle, then go to CONV. in_valid while not in IDLE is ignored; nothing is buffered.
- CONV: t = in_data[15:3].
  - neg = t[12]; mag = neg ? (-t mod 8192) : t, 13-bit unsigned, range 0..4096.
  - int = mag[12:4] (0..256); frac = mag[3:0] * 625 (0..9375, 14 bits).
  - Two iterative double-dabble converters run in parallel for exactly 14 cycles: int zero-extended to 14 bits into 3 BCD digits, frac into 4 BCD digits.
  - If in_fail=1, the conversion result is unused, but CONV still lasts 14 cycles so latency is uniform.
  - After the 14th iteration, go to SEND with byte index=0.
- Record contents:
  - Normal record: sign ('+' 0x2B or '-' 0x2D; '-' only when neg=1), 3 integer digits with leading zeros, '.', 4 fraction digits, then CR LF if EMIT_CRLF. Length is 11 bytes, or 9 with EMIT_CRLF=0.
  - Failure record: 'E','R','R', then CR LF if EMIT_CRLF. Length is 5 bytes, or 3.
  - Digits are 0x30 + BCD value.
- SEND: lasts one cycle. tx_byte = record[index], tx_start=1, timeout counter cleared; go to WAIT.
- WAIT: tx_start=0, tx_byte held, counter increments each cycle.
  - On tx_done_tick: if index = last, go to IDLE; else index+1 and go to SEND.
  - If the counter reaches TX_TIMEOUT-1 without tx_done_tick: pulse tx_abort for one cycle and go to IDLE; the rest of the record is discarded.
  - tx_done_tick and the timeout in the same cycle: done wins.
- tx_done_tick outside WAIT is ignored.
- Latency: accept at edge T. CONV occupies cycles T+1..T+14. The first tx_start is high in cycle T+15. Each subsequent tx_start comes exactly 1 cycle after the previous byte's tx_done_tick. in_ready returns high the cycle after the final tx_done_tick.
- tx_start is never asserted twice without an intervening tx_done_tick or abort.

Test Plan:
- in_data=0x0C80, in_fail=0, UART model returns done 2604 cycles after each start -> bytes "+025.0000\r\n" (2B 30 32 35 2E 30 30 30 30 0D 0A); first tx_start at T+15.
- in_data=0xF378 (-25.0625 C) -> "-025.0625\r\n"; in_data=0x7FF8 -> "+255.9375\r\n"; in_data=0x8000 -> "-256.0000\r\n"; in_data=0x0007 -> "+000.0000\r\n" (low bits ignored).
- in_fail=1, in_data=0x1234 -> "ERR\r\n" (45 52 52 0D 0A), 5 tx_start pulses total.
- TX_TIMEOUT=50, no tx_done_tick after the first start -> tx_abort pulses exactly once, 50 cycles after tx_start; in_ready=1 the next cycle; no further tx_start.
- in_valid held high throughout a record with changing in_data -> only the first value is transmitted; the next record starts from the value present when in_ready returns high.
- reset asserted in WAIT of byte 4 -> next cycle all outputs at reset values; a new in_valid=1 with in_data=0x0C80 yields a complete, correct record.
